// File: rtl/dio_test_sequencer.sv
// Host-side DIO loopback test sequencer: configure tester, settle, poll status N times, switch off, report.
// Latency: SETTLE_CYCLES + dwell*(POLL_INTERVAL+1) cycles plus handshake waits; DIO_SEQ_TIMEOUT_EN adds a handshake timeout.
// Backpressure: every output stream holds tvalid/tdata until its tready; cmd_tready is high only when idle.
module dio_test_sequencer #(
    parameter int SETTLE_CYCLES  = 1024,
    parameter int POLL_INTERVAL  = 4096,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] cmd_tdata,
    input  logic        cmd_tvalid,
    output logic        cmd_tready,
    output logic [31:0] dio_settings_tdata,
    output logic        dio_settings_tvalid,
    input  logic        dio_settings_tready,
    input  logic [31:0] dio_counter_status_tdata,
    input  logic        dio_counter_status_tvalid,
    output logic        dio_counter_status_tready,
    output logic [31:0] result_tdata,
    output logic        result_tvalid,
    input  logic        result_tready,
    output logic        busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_SETTLE, S_POLL, S_WAIT, S_OFF, S_REPORT
    } state_t;

    localparam int CNT_MAX = (SETTLE_CYCLES > POLL_INTERVAL) ? SETTLE_CYCLES : POLL_INTERVAL;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       mode_q;
    logic [11:0]      dwell_q;
    logic [11:0]      poll_cnt_q;
    logic [15:0]      acc_mask_q;
    logic             acc_nr_q;
    logic             acc_ph_q;
    logic [7:0]       fail_q;
    logic [31:0]      res_base;
    logic             stat_fail;
    logic             unused_ok;

`ifdef DIO_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] TO_BIT = 32'h0080_0000;
    logic [TO_W-1:0] to_q;
    logic            to_hit;
    assign to_hit    = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign unused_ok = ^{cmd_tdata[19:18], dio_counter_status_tdata[31:18]};
`else
    assign unused_ok = ^{cmd_tdata[19:18], dio_counter_status_tdata[31:18], TIMEOUT_CYCLES[0]};
`endif

    // Status is consumed only in POLL and only in the cycle the tester offers it, giving a single-cycle pulse.
    assign dio_counter_status_tready = (state_q == S_POLL) && dio_counter_status_tvalid;
    assign stat_fail = |dio_counter_status_tdata[17:0];
    assign res_base  = {fail_q, 1'b0, 5'b0, acc_ph_q, acc_nr_q, acc_mask_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q             <= S_IDLE;
            cnt_q               <= '0;
            mode_q              <= '0;
            dwell_q             <= '0;
            poll_cnt_q          <= '0;
            acc_mask_q          <= '0;
            acc_nr_q            <= 1'b0;
            acc_ph_q            <= 1'b0;
            fail_q              <= '0;
            cmd_tready          <= 1'b1;
            dio_settings_tdata  <= '0;
            dio_settings_tvalid <= 1'b0;
            result_tdata        <= '0;
            result_tvalid       <= 1'b0;
            busy                <= 1'b0;
`ifdef DIO_SEQ_TIMEOUT_EN
            to_q                <= '0;
`endif
        end else begin
`ifdef DIO_SEQ_TIMEOUT_EN
            // Cleared on every cycle that does not stay in a handshake-waiting state.
            to_q <= '0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (cmd_tvalid) begin
                        mode_q              <= cmd_tdata[17:16];
                        dwell_q             <= cmd_tdata[31:20];
                        poll_cnt_q          <= '0;
                        acc_mask_q          <= '0;
                        acc_nr_q            <= 1'b0;
                        acc_ph_q            <= 1'b0;
                        fail_q              <= '0;
                        dio_settings_tdata  <= {14'b0, cmd_tdata[17:0]};
                        dio_settings_tvalid <= 1'b1;
                        cmd_tready          <= 1'b0;
                        busy                <= 1'b1;
                        state_q             <= S_CFG;
                    end
                end
                S_CFG: begin
                    if (dio_settings_tready) begin
                        dio_settings_tvalid <= 1'b0;
                        cnt_q               <= '0;
                        if (mode_q == 2'd0) begin
                            result_tdata  <= res_base;
                            result_tvalid <= 1'b1;
                            state_q       <= S_REPORT;
                        end else if (dwell_q == 12'd0) begin
                            dio_settings_tdata  <= '0;
                            dio_settings_tvalid <= 1'b1;
                            state_q             <= S_OFF;
                        end else begin
                            state_q <= S_SETTLE;
                        end
                    end
`ifdef DIO_SEQ_TIMEOUT_EN
                    else if (to_hit) begin
                        dio_settings_tvalid <= 1'b0;
                        result_tdata        <= res_base | TO_BIT;
                        result_tvalid       <= 1'b1;
                        state_q             <= S_REPORT;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
`endif
                end
                S_SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_POLL;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_POLL: begin
                    if (dio_counter_status_tvalid) begin
                        acc_mask_q <= acc_mask_q | dio_counter_status_tdata[15:0];
                        acc_nr_q   <= acc_nr_q | dio_counter_status_tdata[16];
                        acc_ph_q   <= acc_ph_q | dio_counter_status_tdata[17];
                        if (stat_fail && (fail_q != 8'hFF)) begin
                            fail_q <= fail_q + 1'b1;
                        end
                        poll_cnt_q <= poll_cnt_q + 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_WAIT;
                    end
`ifdef DIO_SEQ_TIMEOUT_EN
                    else if (to_hit) begin
                        result_tdata  <= res_base | TO_BIT;
                        result_tvalid <= 1'b1;
                        state_q       <= S_REPORT;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
`endif
                end
                S_WAIT: begin
                    if (cnt_q == CNT_W'(POLL_INTERVAL - 1)) begin
                        cnt_q <= '0;
                        if (poll_cnt_q == dwell_q) begin
                            dio_settings_tdata  <= '0;
                            dio_settings_tvalid <= 1'b1;
                            state_q             <= S_OFF;
                        end else begin
                            state_q <= S_POLL;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_OFF: begin
                    if (dio_settings_tready) begin
                        dio_settings_tvalid <= 1'b0;
                        result_tdata        <= res_base;
                        result_tvalid       <= 1'b1;
                        state_q             <= S_REPORT;
                    end
`ifdef DIO_SEQ_TIMEOUT_EN
                    else if (to_hit) begin
                        dio_settings_tvalid <= 1'b0;
                        result_tdata        <= res_base | TO_BIT;
                        result_tvalid       <= 1'b1;
                        state_q             <= S_REPORT;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
`endif
                end
                S_REPORT: begin
                    if (result_tready) begin
                        result_tvalid <= 1'b0;
                        cmd_tready    <= 1'b1;
                        busy          <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
